// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the prefetch fetch-entry type
package rv32_pkg;
  localparam int RV32_XLEN = 32;
  localparam logic [RV32_XLEN-1:0] RV32I_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [RV32_XLEN-1:0] pc;
    logic [RV32_XLEN-1:0] word;
  } fetch_entry_t;
endpackage

// File: rtl/rv32_sync_fifo.sv
// rv32_sync_fifo: first-word-fall-through FIFO with synchronous clear and occupancy count
module rv32_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                push,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                pop,
  output logic [WIDTH-1:0]    rdata,
  output logic [LOG2_DEPTH:0] count
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  // pointers and occupancy; a clear coinciding with a push keeps only the new word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      wr_ptr <= LOG2_DEPTH'(push);
      rd_ptr <= '0;
      count <= (LOG2_DEPTH+1)'(push);
    end else begin
      wr_ptr <= wr_ptr + LOG2_DEPTH'(push);
      rd_ptr <= rd_ptr + LOG2_DEPTH'(pop);
      count <= count + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
    end
  end
  // storage write; after a clear the new word lands in slot 0
  always_ff @(posedge clk)
    if (push) mem[clr ? '0 : wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/rv32_fetch_prefetch.sv
// rv32_fetch_prefetch: pipelined instruction prefetch buffer with redirect flush
// RV32_PREFETCH_BYPASS_EN: when defined, a response reaching an empty buffer is presented the same cycle
module rv32_fetch_prefetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int LOG2_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddress,
  output logic        iread,
  input  logic        iwaitrequest,
  input  logic [31:0] ireaddata,
  input  logic        ireaddatavalid,
  input  logic        update_pc,
  input  logic [31:0] new_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int CW = LOG2_DEPTH + 1;
  logic [31:0] fetch_pc, target, tag_pc;
  logic [CW-1:0] outstanding, discard, fifo_count, tag_count;
  logic [CW+1:0] credit;
  logic accept, live_rsp, bypass, fifo_valid, fifo_push, fifo_pop;
  fetch_entry_t head, push_entry;
  assign target = new_pc & ~32'd3;
  assign credit = (CW+2)'(fifo_count) + (CW+2)'(outstanding) + (CW+2)'(discard);
  assign iread = ~reset & (credit < (CW+2)'(DEPTH));
  assign iaddress = (update_pc & ~reset) ? target : fetch_pc;
  assign accept = iread & ~iwaitrequest;
  assign live_rsp = ireaddatavalid & (discard == '0);
  assign fifo_valid = fifo_count != '0;
`ifdef RV32_PREFETCH_BYPASS_EN
  assign bypass = live_rsp & ~fifo_valid & ~update_pc;
`else
  assign bypass = 1'b0;
`endif
  assign fifo_push = live_rsp & ~update_pc & ~(bypass & instr_ready);
  assign fifo_pop = fifo_valid & instr_ready & ~update_pc;
  assign push_entry = {tag_pc, ireaddata};
  assign instr_valid = ~update_pc & (fifo_valid | bypass);
  assign instr = ~instr_valid ? RV32I_NOP : fifo_valid ? head.word : ireaddata;
  assign instr_pc = ~instr_valid ? RESET_VECTOR : fifo_valid ? head.pc : tag_pc;
  // fetch address and request accounting; a redirect turns every live request stale
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_VECTOR;
      outstanding <= '0;
      discard <= '0;
    end else begin
      fetch_pc <= accept ? iaddress + 32'd4 : update_pc ? target : fetch_pc;
      if (update_pc) begin
        outstanding <= CW'(accept);
        discard <= discard + outstanding - CW'(ireaddatavalid);
      end else begin
        outstanding <= outstanding + CW'(accept) - CW'(live_rsp);
        discard <= discard - CW'(ireaddatavalid & ~live_rsp);
      end
    end
  end
  // a response with nothing requested, or a live one into a full buffer, is a bus protocol breach
  always_ff @(posedge clk)
    if (!reset && ireaddatavalid) begin
      assert (tag_count != '0 || discard != '0);
      assert (!live_rsp || fifo_count < CW'(DEPTH));
    end
  rv32_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .LOG2_DEPTH(LOG2_DEPTH)) u_data_fifo (
    .clk(clk),
    .reset(reset),
    .clr(update_pc),
    .push(fifo_push),
    .wdata(push_entry),
    .pop(fifo_pop),
    .rdata(head),
    .count(fifo_count)
  );
  rv32_sync_fifo #(.WIDTH(32), .LOG2_DEPTH(LOG2_DEPTH)) u_tag_fifo (
    .clk(clk),
    .reset(reset),
    .clr(update_pc),
    .push(accept),
    .wdata(iaddress),
    .pop(live_rsp & ~update_pc),
    .rdata(tag_pc),
    .count(tag_count)
  );
endmodule

// File: tb/tb_rv32_fetch_prefetch.sv
// tb_rv32_fetch_prefetch: directed checks of the prefetch unit against a one-cycle pipelined bus model
module tb_rv32_fetch_prefetch;
`ifdef RV32_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] iaddress;
  logic iread;
  logic iwaitrequest = 1'b0;
  logic [31:0] ireaddata = 32'h0;
  logic ireaddatavalid = 1'b0;
  logic update_pc = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit hold_rsp = 1'b0;
  logic [31:0] bq[$];
  int max_q = 0;
  bit acc, rsp;
  logic [31:0] acc_a;
  logic [31:0] got_pc[$];
  logic [31:0] got_w[$];
  int got_cyc[$];

  rv32_fetch_prefetch dut (
    .clk(clk),
    .reset(reset),
    .iaddress(iaddress),
    .iread(iread),
    .iwaitrequest(iwaitrequest),
    .ireaddata(ireaddata),
    .ireaddatavalid(ireaddatavalid),
    .update_pc(update_pc),
    .new_pc(new_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // bus model: accept seen before the edge, answer in order one cycle later
  always begin
    @(negedge clk);
    acc = iread && !iwaitrequest && !reset;
    acc_a = iaddress;
    rsp = ireaddatavalid;
    @(posedge clk);
    #2;
    if (reset) begin
      bq.delete();
      max_q = 0;
    end else begin
      if (rsp) bq.delete(0);
      if (acc) bq.push_back(acc_a);
      if (bq.size() > max_q) max_q = bq.size();
    end
    ireaddatavalid = !reset && !hold_rsp && bq.size() != 0;
    ireaddata = ireaddatavalid ? f(bq[0]) : 32'h0;
  end

  // delivery monitor
  always @(negedge clk) begin
    if (reset) begin
      got_pc.delete();
      got_w.delete();
      got_cyc.delete();
    end else if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_w.push_back(instr);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit rdy, input bit hold);
    @(posedge clk);
    #1;
    reset = 1;
    update_pc = 0;
    new_pc = 0;
    iwaitrequest = 0;
    instr_ready = rdy;
    hold_rsp = hold;
    repeat (3) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (iread !== 1'b0) begin errors++; $display("FAIL reset_iread got=%b exp=0", iread); end
    checks++; if (iaddress !== 32'h0) begin errors++; $display("FAIL reset_iaddress got=%h exp=0", iaddress); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks++; if (iread !== 1'b1 || iaddress !== 32'h0) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", iread, iaddress); end
  endtask

  task automatic test_latency();
    bit found = 0;
    do_reset(1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ireaddatavalid) begin
        found = 1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL latency_rsp got=none exp=response"); end
    checks++; if (instr_valid !== BYP) begin errors++; $display("FAIL latency_same got=%b exp=%b", instr_valid, BYP); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== (BYP ? 32'h4 : 32'h0)) begin errors++; $display("FAIL latency_next got=%b/%h exp=1/%h", instr_valid, instr_pc, BYP ? 32'h4 : 32'h0); end
  endtask

  task automatic test_stream();
    do_reset(1, 0);
    tick(20);
    checks++; if (got_pc.size() < 16) begin errors++; $display("FAIL stream_count got=%0d exp>=16", got_pc.size()); end
    for (int i = 0; i < 16 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4*i) || got_w[i] !== f(32'(4*i)) || got_cyc[i] !== got_cyc[0] + i) begin
        errors++; $display("FAIL stream_seq[%0d] got=%h/%h/c%0d exp=%h/%h/c%0d", i, got_pc[i], got_w[i], got_cyc[i], 32'(4*i), f(32'(4*i)), got_cyc[0] + i);
        break;
      end
    end
    checks++; if (max_q > 4) begin errors++; $display("FAIL stream_outstanding got=%0d exp<=4", max_q); end
  endtask

  task automatic test_backpressure();
    do_reset(0, 0);
    tick(10);
    @(negedge clk);
    checks++; if (iread !== 1'b0) begin errors++; $display("FAIL bp_iread got=%b exp=0", iread); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== f(32'h0)) begin errors++; $display("FAIL bp_head got=%b/%h/%h exp=1/0/%h", instr_valid, instr_pc, instr, f(32'h0)); end
    checks++; if (bq.size() != 0 || got_pc.size() != 0) begin errors++; $display("FAIL bp_idle got=%0d/%0d exp=0/0", bq.size(), got_pc.size()); end
    @(posedge clk);
    #1 instr_ready = 1;
    tick(20);
    checks++; if (got_pc.size() < 12) begin errors++; $display("FAIL bp_count got=%0d exp>=12", got_pc.size()); end
    for (int i = 0; i < 12 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4*i) || got_w[i] !== f(32'(4*i)) || got_cyc[i] !== got_cyc[0] + i) begin
        errors++; $display("FAIL bp_seq[%0d] got=%h/%h/c%0d exp=%h/%h/c%0d", i, got_pc[i], got_w[i], got_cyc[i], 32'(4*i), f(32'(4*i)), got_cyc[0] + i);
        break;
      end
    end
  endtask

  task automatic test_redirect();
    int base;
    do_reset(1, 1);
    tick(3);
    update_pc = 1;
    new_pc = 32'h103;
    base = got_pc.size();
    @(negedge clk);
    checks++; if (iread !== 1'b1 || iaddress !== 32'h100) begin errors++; $display("FAIL redir_req got=%b/%h exp=1/00000100", iread, iaddress); end
    checks++; if (bq.size() != 3) begin errors++; $display("FAIL redir_outstanding got=%0d exp=3", bq.size()); end
    tick(1);
    update_pc = 0;
    hold_rsp = 0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", instr_valid); end
    tick(15);
    checks++; if (got_pc.size() < base + 4) begin errors++; $display("FAIL redir_count got=%0d exp>=%0d", got_pc.size(), base + 4); end
    for (int i = 0; i < 4 && base + i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[base+i] !== 32'h100 + 32'(4*i) || got_w[base+i] !== f(32'h100 + 32'(4*i))) begin
        errors++; $display("FAIL redir_seq[%0d] got=%h/%h exp=%h/%h", i, got_pc[base+i], got_w[base+i], 32'h100 + 32'(4*i), f(32'h100 + 32'(4*i)));
        break;
      end
    end
    checks++; if (max_q > 4) begin errors++; $display("FAIL redir_max_outstanding got=%0d exp<=4", max_q); end
  endtask

  task automatic test_coincident();
    int base, fc;
    do_reset(1, 0);
    tick(8);
    update_pc = 1;
    new_pc = 32'h200;
    base = got_pc.size();
    fc = cyc;
    @(negedge clk);
    checks++; if (ireaddatavalid !== 1'b1 || iread !== 1'b1) begin errors++; $display("FAIL coin_setup got=%b/%b exp=1/1", ireaddatavalid, iread); end
    tick(1);
    update_pc = 0;
    tick(12);
    checks++; if (got_pc.size() < base + 3) begin errors++; $display("FAIL coin_count got=%0d exp>=%0d", got_pc.size(), base + 3); end
    else begin
      checks++; if (got_cyc[base] !== fc + (BYP ? 1 : 2)) begin errors++; $display("FAIL coin_latency got=%0d exp=%0d", got_cyc[base] - fc, BYP ? 1 : 2); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_pc[base+i] !== 32'h200 + 32'(4*i) || got_w[base+i] !== f(32'h200 + 32'(4*i)) || got_cyc[base+i] !== got_cyc[base] + i) begin
          errors++; $display("FAIL coin_seq[%0d] got=%h/%h exp=%h/%h", i, got_pc[base+i], got_w[base+i], 32'h200 + 32'(4*i), f(32'h200 + 32'(4*i)));
          break;
        end
      end
    end
    checks++; if (dut.discard !== '0) begin errors++; $display("FAIL coin_discard got=%0d exp=0", dut.discard); end
  endtask

  task automatic test_stall();
    do_reset(1, 0);
    tick(6);
    iwaitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (iread !== 1'b1 || iaddress !== 32'd24) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/00000018", i, iread, iaddress); end
      tick(1);
    end
    iwaitrequest = 0;
    tick(15);
    checks++; if (got_pc.size() < 12) begin errors++; $display("FAIL stall_count got=%0d exp>=12", got_pc.size()); end
    for (int i = 0; i < 12 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4*i) || got_w[i] !== f(32'(4*i))) begin
        errors++; $display("FAIL stall_seq[%0d] got=%h/%h exp=%h/%h", i, got_pc[i], got_w[i], 32'(4*i), f(32'(4*i)));
        break;
      end
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [31:0] exp_pc[4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    do_reset(1, 0);
    tick(1);
    update_pc = 1;
    new_pc = 32'hFFFF_FFF8;
    base = got_pc.size();
    tick(1);
    update_pc = 0;
    tick(12);
    checks++; if (got_pc.size() < base + 4) begin errors++; $display("FAIL wrap_count got=%0d exp>=%0d", got_pc.size(), base + 4); end
    for (int i = 0; i < 4 && base + i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[base+i] !== exp_pc[i] || got_w[base+i] !== f(exp_pc[i])) begin
        errors++; $display("FAIL wrap_seq[%0d] got=%h/%h exp=%h/%h", i, got_pc[base+i], got_w[base+i], exp_pc[i], f(exp_pc[i]));
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_stall();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
